// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config
//   Write-only SCCB master. After a start request it writes a fixed table of
//   eight {register, value} pairs into the OV7670. The table sets the camera
//   up for QVGA RGB565 output, which the capture block relies on.
//
//   Optional build macro: OV_RESET_WAIT_EN
//     When defined, the bus is held idle for RESET_WAIT_CYCLES clocks after
//     entry 0 (COM7 soft reset) before the rest of the table is written.
//     When undefined, RESET_WAIT_CYCLES has no effect.
//
// Ports
//   clk      system clock, all logic on its rising edge
//   rst      synchronous active-high reset, aborts any transfer at once
//   start    run request, accepted only in IDLE or DONE
//   busy     high from an accepted start until DONE
//   done     high in DONE, cleared by the next accepted start or rst
//   sioc     SCCB clock (push-pull)
//   siod_oe  1 = pull siod low, 0 = release (open drain at the top level)
//   reg_idx  index of the table entry currently being written
module ov7670_sccb_config #(
   parameter int         CLK_HZ            = 100_000_000,
   parameter int         SCCB_HZ           = 100_000,
   parameter logic [7:0] DEV_ADDR          = 8'h42,
   parameter int         NUM_REGS          = 8,
   parameter int         RESET_WAIT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       sioc,
   output logic       siod_oe,
   output logic [2:0] reg_idx
);

   localparam int QTR = CLK_HZ / (4 * SCCB_HZ);
   localparam int QW  = $clog2(QTR + 1);

   typedef enum logic [2:0] {
      IDLE, START, BITS, STOP, GAP, WAIT, DONE
   } state_t;

   state_t          state_reg;
   logic [1:0]      q_reg;      // quarter within the current step
   logic [QW-1:0]   qcnt_reg;   // clocks within the current quarter
   logic [4:0]      bit_reg;    // 0..26, MSB of device address first

`ifdef OV_RESET_WAIT_EN
   localparam int WW = $clog2(RESET_WAIT_CYCLES + 1);
   logic [WW-1:0]   wcnt_reg;
`endif

   function automatic logic [15:0] table_entry(input logic [2:0] idx);
      case (idx)
         3'd0:    table_entry = 16'h1280;  // COM7: soft reset
         3'd1:    table_entry = 16'h1214;  // COM7: QVGA, RGB
         3'd2:    table_entry = 16'h40D0;  // COM15: RGB565, full range
         3'd3:    table_entry = 16'h1101;  // CLKRC: prescale /2
         3'd4:    table_entry = 16'h0C04;  // COM3: enable scaling
         3'd5:    table_entry = 16'h3E19;  // COM14: PCLK divider, manual scaling
         3'd6:    table_entry = 16'h8C00;  // RGB444 off
         default: table_entry = 16'h1500;  // COM10: default sync polarity
      endcase
   endfunction

   logic [15:0] entry;
   logic [26:0] frame;
   logic        tick;
   logic        last_entry;

   assign entry      = table_entry(reg_idx);
   // The 9th bit of each byte is a don't-care ack slot: drive it as 1 (released).
   assign frame      = {DEV_ADDR, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
   assign tick       = (qcnt_reg == QW'(QTR - 1));
   assign last_entry = (reg_idx == 3'(NUM_REGS - 1));

   // Outputs are assigned on the tick that enters each quarter, so the bus
   // shows the new quarter's levels from its first clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         q_reg     <= 2'd0;
         qcnt_reg  <= '0;
         bit_reg   <= 5'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sioc      <= 1'b1;
         siod_oe   <= 1'b0;
         reg_idx   <= 3'd0;
`ifdef OV_RESET_WAIT_EN
         wcnt_reg  <= '0;
`endif
      end else begin
         if (state_reg != IDLE && state_reg != DONE)
            qcnt_reg <= tick ? '0 : qcnt_reg + 1'b1;
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  state_reg <= START;
                  q_reg     <= 2'd0;
                  qcnt_reg  <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  reg_idx   <= 3'd0;
               end
            end
            START: if (tick) begin
               q_reg <= q_reg + 2'd1;
               case (q_reg)
                  2'd1: siod_oe <= 1'b1;          // SDA falls while SCL high
                  2'd2: sioc    <= 1'b0;
                  2'd3: begin
                     state_reg <= BITS;
                     bit_reg   <= 5'd0;
                     siod_oe   <= ~frame[26];
                  end
                  default: ;
               endcase
            end
            BITS: if (tick) begin
               q_reg <= q_reg + 2'd1;
               case (q_reg)
                  2'd0: sioc <= 1'b1;
                  2'd2: sioc <= 1'b0;
                  2'd3: begin
                     if (bit_reg == 5'd26) begin
                        state_reg <= STOP;
                        siod_oe   <= 1'b1;
                     end else begin
                        bit_reg <= bit_reg + 5'd1;
                        siod_oe <= ~frame[5'd25 - bit_reg];
                     end
                  end
                  default: ;
               endcase
            end
            STOP: if (tick) begin
               q_reg <= q_reg + 2'd1;
               case (q_reg)
                  2'd0: sioc      <= 1'b1;
                  2'd1: siod_oe   <= 1'b0;        // SDA rises while SCL high
                  2'd3: state_reg <= GAP;
                  default: ;
               endcase
            end
            GAP: if (tick) begin
               q_reg <= q_reg + 2'd1;
               if (q_reg == 2'd3) begin
                  if (last_entry) begin
                     state_reg <= DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
`ifdef OV_RESET_WAIT_EN
                  end else if (reg_idx == 3'd0) begin
                     state_reg <= WAIT;
                     wcnt_reg  <= '0;
`endif
                  end else begin
                     state_reg <= START;
                     reg_idx   <= reg_idx + 3'd1;
                  end
               end
            end
`ifdef OV_RESET_WAIT_EN
            WAIT: begin
               wcnt_reg <= wcnt_reg + 1'b1;
               if (wcnt_reg == WW'(RESET_WAIT_CYCLES - 1)) begin
                  state_reg <= START;
                  q_reg     <= 2'd0;
                  qcnt_reg  <= '0;
                  reg_idx   <= 3'd1;
               end
            end
`endif
            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
               sioc      <= 1'b1;
               siod_oe   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config: decodes the SCCB bus into frames and checks
// them, plus status timing, against the expected table and run length.
module tb_ov7670_sccb_config;

   localparam int QTR    = 10;
   localparam int WRITE  = 120 * QTR;
`ifdef OV_RESET_WAIT_EN
   localparam int WAITC  = 50;
`else
   localparam int WAITC  = 0;
`endif
   localparam int RUNLEN = 8 * WRITE + WAITC;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       busy, done, sioc, siod_oe;
   logic [2:0] reg_idx;

   ov7670_sccb_config #(
      .CLK_HZ(400), .SCCB_HZ(10), .DEV_ADDR(8'h42),
      .NUM_REGS(8), .RESET_WAIT_CYCLES(50)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .sioc(sioc), .siod_oe(siod_oe), .reg_idx(reg_idx)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected {device, register, value} per table entry.
   logic [23:0] exp_frames [8] = '{24'h421280, 24'h421214, 24'h4240D0, 24'h421101,
                                   24'h420C04, 24'h423E19, 24'h428C00, 24'h421500};

   // Bus decoder: start/stop conditions and bits on sioc rising edges.
   logic [23:0] frames [$];
   logic [27:0] sh = '0;
   int          nbits = 0;
   bit          inframe = 0;
   logic        prev_sioc = 1'b1, prev_oe = 1'b0;
   int          first_fall = -1;
   int          done_cyc = -1;
   int          viol = 0;
   logic [26:0] f;

   always @(negedge clk) begin
      if (rst) begin
         nbits   = 0;
         inframe = 0;
      end else if (prev_sioc && sioc && !prev_oe && siod_oe) begin
         inframe = 1;
         nbits   = 0;
         if (first_fall < 0) first_fall = cyc;
      end else if (prev_sioc && sioc && prev_oe && !siod_oe) begin
         // 27 data bits plus the sioc rise at the start of STOP
         if (inframe && nbits == 28) begin
            f = sh[27:1];
            frames.push_back({f[26:19], f[17:10], f[8:1]});
         end
         inframe = 0;
      end else if (!prev_sioc && sioc && inframe) begin
         sh = {sh[26:0], ~siod_oe};
         nbits++;
      end
      if (busy && done) viol++;
      if (done && done_cyc < 0) done_cyc = cyc;
      prev_sioc = sioc;
      prev_oe   = siod_oe;
   end

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;   // rst must win over start
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({sioc, siod_oe, busy, done, reg_idx} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_state: got sioc=%b oe=%b busy=%b done=%b idx=%0d, want 1 0 0 0 0",
                  sioc, siod_oe, busy, done, reg_idx);
      end
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b want 0", busy);
      end
      $display("reset: state checked, idle held");
   endtask

   // One complete run. Optionally pulses start while entry 3 is in flight.
   task automatic do_run(input string name, input bit inject);
      int t0, target;
      frames.delete();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      first_fall = -1;
      done_cyc   = -1;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || reg_idx !== 3'd0) begin
         n_fail++;
         $display("FAIL %s_accept: busy=%b done=%b idx=%0d, want 1 0 0", name, busy, done, reg_idx);
      end
      @(negedge clk);
      start = 1'b0;
      if (inject) begin
         target = t0 + 3 * WRITE + WAITC + int'($urandom_range(0, WRITE - 1));
         while (cyc < target) @(negedge clk);
         n_cmp++;
         if (reg_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL %s_inject_idx: idx=%0d want 3", name, reg_idx);
         end
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int i = 0; i < RUNLEN + 200 && done_cyc < 0; i++) @(negedge clk);
      n_cmp++;
      if (done_cyc < 0 || done_cyc - t0 != RUNLEN) begin
         n_fail++;
         $display("FAIL %s_done_time: got %0d clks want %0d", name, done_cyc - t0, RUNLEN);
      end
      n_cmp++;
      if (first_fall - t0 != 2 * QTR) begin
         n_fail++;
         $display("FAIL %s_first_start: got %0d clks want %0d", name, first_fall - t0, 2 * QTR);
      end
      n_cmp++;
      if (frames.size() != 8) begin
         n_fail++;
         $display("FAIL %s_frame_count: got %0d want 8", name, frames.size());
      end
      for (int i = 0; i < 8 && i < frames.size(); i++) begin
         n_cmp++;
         if (frames[i] !== exp_frames[i]) begin
            n_fail++;
            $display("FAIL %s_frame%0d: got %h want %h", name, i, frames[i], exp_frames[i]);
         end
      end
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b1 || reg_idx !== 3'd7 || sioc !== 1'b1 || siod_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_done_state: busy=%b done=%b idx=%0d sioc=%b oe=%b, want 0 1 7 1 0",
                  name, busy, done, reg_idx, sioc, siod_oe);
      end
      $display("%s: %0d frames, done after %0d clks", name, frames.size(), done_cyc - t0);
   endtask

   task automatic test_full_run();
      do_run("full_run", 1'b0);
   endtask

   task automatic test_back_to_back();
      do_run("back_to_back", 1'b0);
   endtask

   task automatic test_start_ignored();
      do_run("start_ignored", 1'b1);
   endtask

   task automatic test_rst_mid();
      int t0, target;
      frames.delete();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      // entry 5, bit 12 begins 4 + 12*4 quarters into the write
      target = t0 + 5 * WRITE + WAITC + 52 * QTR + int'($urandom_range(0, 4 * QTR - 1));
      while (cyc < target) @(negedge clk);
      n_cmp++;
      if (reg_idx !== 3'd5 || frames.size() != 5) begin
         n_fail++;
         $display("FAIL rst_mid_position: idx=%0d frames=%0d, want 5 5", reg_idx, frames.size());
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({sioc, siod_oe, busy, done, reg_idx} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL rst_mid_abort: sioc=%b oe=%b busy=%b done=%b idx=%0d, want 1 0 0 0 0",
                  sioc, siod_oe, busy, done, reg_idx);
      end
      @(negedge clk);
      rst = 1'b0;
      $display("rst_mid: aborted at cycle %0d of run", target - t0);
      repeat ($urandom_range(1, 10)) @(posedge clk);
      do_run("restart", 1'b0);
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_back_to_back();
      test_start_ignored();
      test_rst_mid();
      n_cmp++;
      if (viol !== 0) begin
         n_fail++;
         $display("FAIL busy_done_exclusive: %0d cycles with both high, want 0", viol);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
